// File: rtl/cnu_msg_gen.sv
// Check-node message regenerator: expands {min, min2, min_idx, signs} into D
// offset-min-sum extrinsic messages, one per cycle, behind a 2-entry ping-pong buffer.
module cnu_msg_gen #(
    parameter int data_w = 8,
    parameter int idx_w  = 8,
    parameter int D      = 5,
    parameter int OFFSET = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [data_w-1:0] in_min,
    input  logic [data_w-1:0] in_min2,
    input  logic [idx_w-1:0]  in_min_idx,
    input  logic [D-1:0]      in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [data_w-1:0] out_mag,
    output logic              out_sign,
    output logic [idx_w-1:0]  out_idx,
    output logic              out_last,
    output logic              busy
);
    localparam logic [data_w:0]  OFF_W  = (data_w + 1)'(OFFSET);
    localparam logic [idx_w-1:0] K_LAST = idx_w'(D - 1);

    logic [1:0]                   count_q, count_d;
    logic                         wr_q, wr_d, rd_q, rd_d;
    logic [idx_w-1:0]             k_q, k_d;
    logic [1:0][data_w-1:0]       min_q, min_d, min2_q, min2_d;
    logic [1:0][idx_w-1:0]        midx_q, midx_d;
    logic [1:0][D-1:0]            sign_q, sign_d;
    logic [1:0]                   par_q, par_d;
    logic                         out_valid_q, out_valid_d;
    logic [data_w-1:0]            out_mag_q, out_mag_d;
    logic                         out_sign_q, out_sign_d;
    logic [idx_w-1:0]             out_idx_q, out_idx_d;
    logic                         out_last_q, out_last_d;

    logic              push, load, pop, sbit;
    logic [data_w-1:0] sel_mag;
    logic [data_w:0]   diff;

    assign in_ready = (count_q < 2'd2);
    assign push     = in_valid && in_ready;
    assign load     = (count_q != 2'd0) && (!out_valid_q || out_ready);
    assign pop      = load && (k_q == K_LAST);

    always_comb begin
        count_d     = count_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        k_d         = k_q;
        min_d       = min_q;
        min2_d      = min2_q;
        midx_d      = midx_q;
        sign_d      = sign_q;
        par_d       = par_q;
        out_valid_d = out_valid_q;
        out_mag_d   = out_mag_q;
        out_sign_d  = out_sign_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        sbit        = 1'b0;

        if (push) begin
            min_d[wr_q]  = in_min;
            min2_d[wr_q] = in_min2;
            midx_d[wr_q] = in_min_idx;
            sign_d[wr_q] = in_sign;
            par_d[wr_q]  = ^in_sign;
            wr_d         = ~wr_q;
        end

        // The edge that owns min sees min2; an out-of-range index matches nothing.
        sel_mag = (k_q == midx_q[rd_q]) ? min2_q[rd_q] : min_q[rd_q];
        diff    = {1'b0, sel_mag} - OFF_W;
        for (int i = 0; i < D; i++) begin
            if (k_q == idx_w'(i)) sbit = sign_q[rd_q][i];
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_mag_d   = diff[data_w] ? '0 : diff[data_w-1:0];
            out_sign_d  = par_q[rd_q] ^ sbit;
            out_idx_d   = k_q;
            out_last_d  = (k_q == K_LAST);
            if (k_q == K_LAST) begin
                k_d  = '0;
                rd_d = ~rd_q;
            end else begin
                k_d = k_q + 1'b1;
            end
        end else if (out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            k_q         <= '0;
            min_q       <= '0;
            min2_q      <= '0;
            midx_q      <= '0;
            sign_q      <= '0;
            par_q       <= '0;
            out_valid_q <= 1'b0;
            out_mag_q   <= '0;
            out_sign_q  <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            k_q         <= k_d;
            min_q       <= min_d;
            min2_q      <= min2_d;
            midx_q      <= midx_d;
            sign_q      <= sign_d;
            par_q       <= par_d;
            out_valid_q <= out_valid_d;
            out_mag_q   <= out_mag_d;
            out_sign_q  <= out_sign_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mag   = out_mag_q;
    assign out_sign  = out_sign_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = (count_q != 2'd0) || out_valid_q;

endmodule

// File: doc/cnu_msg_gen.md
Name: cnu_msg_gen

Overview:
- Decompression end of the check-node unit: consumes the compressed check-node state produced by the min/min2 comparison tree (min, min2, min_idx, plus the D input sign bits).
- Serially regenerates the D extrinsic check-to-variable messages, one per cycle, with offset-min-sum correction.
- Two-entry ping-pong buffer so the next state can load while the current one streams out; valid/ready handshake on both sides.

Parameters:
- data_w, 8, magnitude width of min/min2/out_mag
- idx_w, 8, edge index width
- D, 5, check-node degree (edges per frame)
- OFFSET, 0, offset subtracted from every output magnitude, saturating at 0

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  compressed state valid
- in_ready  out  1  buffer can accept
- in_min  in  data_w  smallest magnitude
- in_min2  in  data_w  second-smallest magnitude
- in_min_idx  in  idx_w  edge index of in_min
- in_sign  in  D  sign bit of each input message, bit k = edge k
- out_valid  out  1  message valid
- out_ready  in  1  downstream accepts
- out_mag  out  data_w  message magnitude
- out_sign  out  1  message sign
- out_idx  out  idx_w  edge index k of message
- out_last  out  1  high on edge D-1
- busy  out  1  buffer non-empty or out_valid high

Behaviour:
- Reset is asynchronous, active-high on rst; clock is clk.
- Reset state: count=0, rd/wr pointers=0, k=0, out_valid=0, out_mag=0, out_sign=0, out_idx=0, out_last=0, busy=0.
- Buffer:
  - Two entries {min, min2, min_idx, sign, parity}, where parity = XOR of in_sign, computed at push.
  - in_ready = (count<2), from registered count only. No push while full, even when a pop occurs in the same cycle.
  - Push = in_valid && in_ready; writes wr entry and toggles wr pointer.
- Output load:
  - Condition: count>0 && (!out_valid || out_ready).
  - Head entry h, edge counter k:
    - out_mag <= sat0((k==h.min_idx ? h.min2 : h.min) - OFFSET)
    - out_sign <= h.parity ^ h.sign[k]
    - out_idx <= k
    - out_last <= (k==D-1)
    - out_valid <= 1
  - Then k <= k+1. If k==D-1: k <= 0, pop the head (toggle rd pointer).
- If there is no load and out_ready && out_valid, then out_valid <= 0. Outputs hold while out_valid && !out_ready.
- count: +1 on push only, -1 on pop only, unchanged on both.
- Latency: an entry pushed at edge t (empty buffer, idle output) gives first out_valid after edge t+1.
- Throughput: with out_ready=1, one message per cycle. Consecutive frames stream with no bubble when the next entry is buffered.
- min_idx >= D (e.g. the odd-D pad index D from the tree): matches no edge, so all D edges use min.
- Subtraction is done in data_w+1 bits; a negative result clamps to 0. OFFSET=0 passes magnitudes unchanged.
- min==min2 is legal: all outputs equal min-OFFSET.
- Reset mid-frame: partial frame is discarded, state returns to reset values, and no stale message appears after rst deasserts.
- busy = (count!=0) || out_valid.

Test Plan:
- D=5, OFFSET=1; push min=3, min2=7, idx=2, sign=5'b00101; out_ready=1 -> 5 consecutive messages mag 2,2,6,2,2; sign 1,0,1,0,0; idx 0..4; out_last only on idx 4; first valid one cycle after push.
- OFFSET=1, min=0, min2=1, idx=0, sign=0 -> all mags 0; sign=5'b11111 (parity 1) -> all signs 0.
- Three pushes back-to-back, out_ready=1 -> in_ready low after the 2nd push, rises after the first frame's idx 4 handshake; 15 messages with no bubbles between frames.
- out_ready toggled pseudo-randomly -> outputs stable while stalled; no message lost or duplicated; order idx 0..4 per frame.
- min_idx=5 with D=5, min=4, min2=9, OFFSET=0 -> all five mags 4.
- rst asserted after the 2nd message of a frame -> out_valid=0, in_ready=1, busy=0 immediately; a new push gives a fresh frame starting at idx 0.
